// File: rtl/regfile_sb_pkg.sv
// Shared types and constants for the write-back register file slice.
//   reg_addr_t / reg_data_t : register index and data types (default widths)
//   REG_ZERO                : index of the hard-wired zero register
//   EN_VALID / EN_INVALID   : enable encodings
//   DATA_INVALID / ADDR_INVALID : idle values for data and index fields
//   wb_info_t               : MEM/WB record (pc, inst, rw_data, rw_addr, rw_en)
package regfile_sb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    typedef logic [DATA_W-1:0] reg_data_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO     = '0;
    localparam reg_addr_t ADDR_INVALID = '0;
    localparam reg_data_t DATA_INVALID = '0;
    localparam logic      EN_VALID     = 1'b1;
    localparam logic      EN_INVALID   = 1'b0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        reg_data_t   rw_data;
        reg_addr_t   rw_addr;
        logic        rw_en;
    } wb_info_t;

endpackage

// File: rtl/regfile_sb_cnt.sv
// One scoreboard pending-write counter.
//   clk, rst       : clock, synchronous active-low reset
//   inc, dec       : issue / retire for this register
//   clr            : flush, overrides inc and dec
//   cnt            : current pending count
//   underflow      : retirement seen while the count is zero (combinational)
module regfile_sb_cnt
    import regfile_sb_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 2
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 dec,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 underflow
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec && cnt != CNT_MAX) begin
            cnt <= cnt + CNT_WIDTH'(1);
        end else if (dec && !inc && cnt != '0) begin
            cnt <= cnt - CNT_WIDTH'(1);
        end
    end

    assign underflow = dec && (cnt == '0);

endmodule

// File: rtl/regfile_sb.sv
// Write-back register file with per-register pending-write scoreboard.
//   clk, rst                       : clock, synchronous active-low reset
//   rw_en, rw_addr, rw_data        : WB-stage write port (also retires scoreboard entry)
//   rdN_en, rdN_addr               : ID-stage read ports 0/1
//   rdN_data, rdN_busy             : read data (with WB bypass), pending-write flag
//   issue_en, issue_addr           : ID marks a destination as pending
//   issue_full                     : destination counter saturated, ID must stall
//   flush                          : clears all pending counts
//   sb_err                         : sticky retirement-with-zero-count error
// Optional build macro REGFILE_DBG_PORT_EN adds dbg_addr / dbg_data / dbg_pending.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_NUM    = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned CNT_WIDTH  = 2
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rw_en,
    input  logic [ADDR_WIDTH-1:0] rw_addr,
    input  logic [DATA_WIDTH-1:0] rw_data,
    input  logic                  rd0_en,
    input  logic [ADDR_WIDTH-1:0] rd0_addr,
    output logic [DATA_WIDTH-1:0] rd0_data,
    output logic                  rd0_busy,
    input  logic                  rd1_en,
    input  logic [ADDR_WIDTH-1:0] rd1_addr,
    output logic [DATA_WIDTH-1:0] rd1_data,
    output logic                  rd1_busy,
    input  logic                  issue_en,
    input  logic [ADDR_WIDTH-1:0] issue_addr,
    output logic                  issue_full,
    input  logic                  flush,
    output logic                  sb_err
`ifdef REGFILE_DBG_PORT_EN
    ,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data,
    output logic                  dbg_pending
`endif
);

    localparam logic [ADDR_WIDTH-1:0] R0        = ADDR_WIDTH'(REG_ZERO);
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = DATA_WIDTH'(DATA_INVALID);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;

    logic [DATA_WIDTH-1:0] regs  [REG_NUM];
    logic [CNT_WIDTH-1:0]  cnt   [REG_NUM];
    logic [CNT_WIDTH-1:0]  cnt_q [1:REG_NUM-1];
    logic                  uf_q  [1:REG_NUM-1];
    logic                  inc   [REG_NUM];
    logic                  dec   [REG_NUM];
    logic                  wr_hit;
    logic                  issue_full_raw;
    logic                  any_uf;
    logic [CNT_WIDTH-1:0]  rem0;
    logic [CNT_WIDTH-1:0]  rem1;

    assign wr_hit = (rw_en == EN_VALID) && (rw_addr != R0);

    // A retirement to the issue target in the same cycle frees a slot, so the
    // saturated count does not block that issue.
    assign issue_full_raw = issue_en && (issue_addr != R0) &&
                            (cnt[issue_addr] == CNT_MAX) &&
                            !(wr_hit && rw_addr == issue_addr);
    assign issue_full = rst && issue_full_raw;

    always_comb begin
        cnt[0] = '0;
        for (int unsigned i = 1; i < REG_NUM; i++) begin
            cnt[i] = cnt_q[i];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < REG_NUM; i++) begin
            dec[i] = wr_hit && (rw_addr == ADDR_WIDTH'(i));
            inc[i] = issue_en && (issue_addr != R0) &&
                     (issue_addr == ADDR_WIDTH'(i)) && !issue_full_raw;
        end
    end

    for (genvar g = 1; g < REG_NUM; g++) begin : g_cnt
        regfile_sb_cnt #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (inc[g]),
            .dec       (dec[g]),
            .clr       (flush),
            .cnt       (cnt_q[g]),
            .underflow (uf_q[g])
        );
    end

    always_comb begin
        any_uf = 1'b0;
        for (int unsigned i = 1; i < REG_NUM; i++) begin
            any_uf = any_uf | uf_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sb_err <= 1'b0;
        end else if (any_uf) begin
            sb_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_hit) begin
            regs[rw_addr] <= rw_data;
        end
    end

    // Read ports: zero for r0/disabled/reset, else WB bypass, else array.
    always_comb begin
        rd0_data = ZERO_DATA;
        if (rst && rd0_en && rd0_addr != R0) begin
            if (rw_en && rw_addr == rd0_addr) rd0_data = rw_data;
            else                              rd0_data = regs[rd0_addr];
        end
        rd1_data = ZERO_DATA;
        if (rst && rd1_en && rd1_addr != R0) begin
            if (rw_en && rw_addr == rd1_addr) rd1_data = rw_data;
            else                              rd1_data = regs[rd1_addr];
        end
    end

    // A write retiring this cycle no longer counts as pending.
    assign rem0     = cnt[rd0_addr] - CNT_WIDTH'(dec[rd0_addr]);
    assign rem1     = cnt[rd1_addr] - CNT_WIDTH'(dec[rd1_addr]);
    assign rd0_busy = rst && rd0_en && (rd0_addr != R0) && (rem0 != '0);
    assign rd1_busy = rst && rd1_en && (rd1_addr != R0) && (rem1 != '0);

`ifdef REGFILE_DBG_PORT_EN
    always_comb begin
        dbg_data    = (dbg_addr == R0) ? ZERO_DATA : regs[dbg_addr];
        dbg_pending = 1'b0;
        for (int unsigned i = 1; i < REG_NUM; i++) begin
            dbg_pending = dbg_pending | (cnt[i] != '0);
        end
    end
`endif

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst, rw_en, rd0_en, rd1_en, issue_en, flush;
    logic [4:0]  rw_addr, rd0_addr, rd1_addr, issue_addr;
    logic [31:0] rw_data;
    logic [31:0] rd0_data, rd1_data;
    logic        rd0_busy, rd1_busy, issue_full, sb_err;

    int n_chk = 0;
    int n_err = 0;

    // Reference state: architectural values, pending counts, sticky error.
    logic [31:0] reg_m [32];
    int          cnt_m [32];
    bit          err_m;

    always #5 clk = ~clk;

    regfile_sb #(
        .DATA_WIDTH (32),
        .REG_NUM    (32),
        .ADDR_WIDTH (5),
        .CNT_WIDTH  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rw_en      (rw_en),
        .rw_addr    (rw_addr),
        .rw_data    (rw_data),
        .rd0_en     (rd0_en),
        .rd0_addr   (rd0_addr),
        .rd0_data   (rd0_data),
        .rd0_busy   (rd0_busy),
        .rd1_en     (rd1_en),
        .rd1_addr   (rd1_addr),
        .rd1_data   (rd1_data),
        .rd1_busy   (rd1_busy),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .issue_full (issue_full),
        .flush      (flush),
        .sb_err     (sb_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_rd(input logic en, input logic [4:0] a);
        if (!rst || !en || a == 0) return 32'h0;
        if (rw_en && rw_addr == a) return rw_data;
        return reg_m[a];
    endfunction

    function automatic logic m_busy(input logic en, input logic [4:0] a);
        int d;
        if (!rst || !en || a == 0) return 1'b0;
        d = (rw_en && rw_addr == a) ? 1 : 0;
        return ((cnt_m[a] - d + 4) % 4) != 0;
    endfunction

    function automatic logic m_full();
        if (!rst || !issue_en || issue_addr == 0) return 1'b0;
        return cnt_m[issue_addr] == 3 && !(rw_en && rw_addr == issue_addr);
    endfunction

    task automatic idle();
        rw_en = 0; rw_addr = 0; rw_data = 0;
        rd0_en = 0; rd0_addr = 0; rd1_en = 0; rd1_addr = 0;
        issue_en = 0; issue_addr = 0; flush = 0;
    endtask

    // Settle combinational outputs and compare against the reference.
    task automatic eval();
        #3;
        check("rd0_data",   rd0_data,   m_rd(rd0_en, rd0_addr));
        check("rd1_data",   rd1_data,   m_rd(rd1_en, rd1_addr));
        check("rd0_busy",   32'(rd0_busy),   32'(m_busy(rd0_en, rd0_addr)));
        check("rd1_busy",   32'(rd1_busy),   32'(m_busy(rd1_en, rd1_addr)));
        check("issue_full", 32'(issue_full), 32'(m_full()));
        check("sb_err",     32'(sb_err),     32'(err_m));
    endtask

    // Clock edge, then advance the reference using the inputs held across it.
    task automatic tick();
        bit full;
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                reg_m[i] = 0;
                cnt_m[i] = 0;
            end
            err_m = 0;
        end else begin
            full = m_full();
            if (rw_en && rw_addr != 0) begin
                reg_m[rw_addr] = rw_data;
                if (cnt_m[rw_addr] == 0) err_m = 1;
            end
            if (flush) begin
                for (int i = 0; i < 32; i++) cnt_m[i] = 0;
            end else begin
                if (issue_en && issue_addr != 0 && !full) cnt_m[issue_addr]++;
                if (rw_en && rw_addr != 0 && cnt_m[rw_addr] > 0) cnt_m[rw_addr]--;
            end
        end
        #1;
    endtask

    task automatic cyc();
        eval();
        tick();
    endtask

    function automatic logic [4:0] pick_addr();
        if ($urandom_range(0, 3) != 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) begin
            reg_m[i] = 0;
            cnt_m[i] = 0;
        end
        err_m = 0;
        idle();
        rst = 0;
        @(posedge clk); #1;
        rst = 0; rd0_en = 1; rd0_addr = 5; rd1_en = 1; rd1_addr = 3;
        cyc();
        rst = 1; idle();

        // mark r5 and r7 pending so their writes retire cleanly
        issue_en = 1; issue_addr = 5; cyc();
        issue_addr = 7; cyc();
        idle();
        rw_en = 1; rw_addr = 5; rw_data = 32'hDEADBEEF; cyc();
        idle();
        rd0_en = 1; rd0_addr = 5; rd1_en = 1; rd1_addr = 0;
        rw_en = 1; rw_addr = 7; rw_data = 32'h1234;
        eval();
        check("rd0_r5", rd0_data, 32'hDEADBEEF);
        check("rd1_r0", rd1_data, 32'h0);
        rd0_addr = 7;
        #1;
        check("rd0_bypass_r7", rd0_data, 32'h1234);
        tick();
        idle();
        rw_en = 1; rw_addr = 0; rw_data = 32'hFFFF; rd0_en = 1; rd0_addr = 0; cyc();
        idle(); rd0_en = 1; rd0_addr = 0; rd1_en = 1; rd1_addr = 7;
        eval();
        check("r0_after_write", rd0_data, 32'h0);
        check("sb_err_clean", 32'(sb_err), 32'h0);
        tick();

        // saturate r3, then drain it
        idle(); rd0_en = 1; rd0_addr = 3; issue_en = 1; issue_addr = 3;
        repeat (3) cyc();
        eval();
        check("r3_busy", 32'(rd0_busy), 32'h1);
        check("r3_full", 32'(issue_full), 32'h1);
        tick();
        issue_en = 0; rw_en = 1; rw_addr = 3;
        for (int k = 0; k < 3; k++) begin
            rw_data = 32'h300 + 32'(k);
            eval();
            if (k == 2) check("r3_busy_last_retire", 32'(rd0_busy), 32'h0);
            else        check("r3_busy_draining", 32'(rd0_busy), 32'h1);
            tick();
        end

        // simultaneous issue and retire on r4
        idle(); issue_en = 1; issue_addr = 4; cyc();
        rd0_en = 1; rd0_addr = 4; rw_en = 1; rw_addr = 4; rw_data = 32'h44;
        eval();
        check("r4_busy_same_cycle", 32'(rd0_busy), 32'h0);
        tick();
        idle(); rd0_en = 1; rd0_addr = 4;
        eval();
        check("r4_still_pending", 32'(rd0_busy), 32'h1);
        tick();
        rw_en = 1; rw_addr = 4; rw_data = 32'h45; cyc();

        // retirement with zero count
        idle(); rw_en = 1; rw_addr = 9; rw_data = 32'h99; cyc();
        idle();
        eval();
        check("sb_err_set", 32'(sb_err), 32'h1);
        tick();
        cyc(); cyc();

        // flush overrides a same-cycle issue
        issue_en = 1; issue_addr = 2; cyc();
        issue_addr = 6; cyc();
        issue_addr = 8; flush = 1; cyc();
        idle(); rd0_en = 1; rd0_addr = 2; rd1_en = 1; rd1_addr = 8;
        eval();
        check("flush_r2", 32'(rd0_busy), 32'h0);
        check("flush_r8", 32'(rd1_busy), 32'h0);
        rd0_addr = 6;
        #1;
        check("flush_r6", 32'(rd0_busy), 32'h0);
        tick();

        // reset mid-stream
        idle(); issue_en = 1; issue_addr = 10; cyc();
        idle(); rw_en = 1; rw_addr = 11; rw_data = 32'hABCD; cyc();
        idle(); rst = 0; cyc();
        rst = 1; rd0_en = 1; rd0_addr = 11; rd1_en = 1; rd1_addr = 10;
        eval();
        check("post_rst_data", rd0_data, 32'h0);
        check("post_rst_busy", 32'(rd1_busy), 32'h0);
        check("post_rst_err", 32'(sb_err), 32'h0);
        tick();

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst        = ($urandom_range(0, 99) != 0);
            rw_en      = $urandom_range(0, 1);
            rw_addr    = pick_addr();
            rw_data    = $urandom;
            rd0_en     = ($urandom_range(0, 3) != 0);
            rd0_addr   = pick_addr();
            rd1_en     = ($urandom_range(0, 3) != 0);
            rd1_addr   = pick_addr();
            issue_en   = $urandom_range(0, 1);
            issue_addr = pick_addr();
            flush      = ($urandom_range(0, 29) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
